// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, control width and checker FSM states.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_RUN  = 2'd1,
    CHK_DONE = 2'd2
  } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational ALU reference: expected result, flags and reserved-opcode indication.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [ALU_CTRL_W-1:0] op,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  less_than,
  output logic                  less_than_unsigned,
  output logic                  reserved
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;

  assign shamt = b[SH_W-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Opcode decode into the expected result; unknown opcodes flag reserved
  always_comb begin
    result   = '0;
    reserved = 1'b0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = WIDTH'(lt_s);
      ALU_SLTU: result = WIDTH'(lt_u);
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      default:  reserved = 1'b1;
    endcase
  end

  // Flags: compare flags are independent of the opcode
  assign zero               = (result == '0);
  assign less_than          = lt_s;
  assign less_than_unsigned = lt_u;

endmodule

// File: rtl/alu_result_checker.sv
// On-chip ALU result checker: samples ALU traffic, recomputes expectations and tallies outcomes.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_txn,
  input  logic                  smp_valid,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  zero,
  input  logic                  less_than,
  input  logic                  less_than_unsigned,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [CNT_W-1:0]      skip_cnt,
  output logic [CNT_W-1:0]      first_fail_idx,
  output logic [ALU_CTRL_W-1:0] first_fail_op,
  output logic [WIDTH-1:0]      first_fail_exp
);

  chk_state_e state;

  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] idx;

  // Stage-1 capture of one ALU transaction
  logic                  s1_valid;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;
  logic [ALU_CTRL_W-1:0] s1_op;
  logic [WIDTH-1:0]      s1_result;
  logic                  s1_zero;
  logic                  s1_lt;
  logic                  s1_ltu;
  logic [CNT_W-1:0]      s1_idx;

  // Stage-2 expectations
  logic [WIDTH-1:0] exp_result;
  logic             exp_zero;
  logic             exp_lt;
  logic             exp_ltu;
  logic             exp_reserved;

  logic start_c;
  logic sample_c;
  logic last_c;
  logic match_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign start_c  = start && (state != CHK_RUN);
  assign sample_c = (state == CHK_RUN) && smp_valid && (idx != num_q);
  // All samples taken and stage 1 drained, so the last tally has landed
  assign last_c   = (state == CHK_RUN) && (idx == num_q) && !s1_valid;

  // Run control FSM; a zero-length run spends one cycle in RUN, giving done one cycle after start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CHK_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      num_q    <= '0;
      idx      <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= sample_c;
      if (sample_c) begin
        idx <= idx + CNT_W'(1);
      end
      case (state)
        CHK_IDLE, CHK_DONE: begin
          if (start) begin
            state <= CHK_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
            num_q <= num_txn;
            idx   <= '0;
          end
        end
        CHK_RUN: begin
          if (last_c) begin
            state <= CHK_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= CHK_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Stage-1 datapath capture; qualified downstream by s1_valid
  always_ff @(posedge clk) begin
    if (sample_c) begin
      s1_a      <= a;
      s1_b      <= b;
      s1_op     <= alu_control;
      s1_result <= alu_result;
      s1_zero   <= zero;
      s1_lt     <= less_than;
      s1_ltu    <= less_than_unsigned;
      s1_idx    <= idx;
    end
  end

  alu_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .a                 (s1_a),
    .b                 (s1_b),
    .op                (s1_op),
    .result            (exp_result),
    .zero              (exp_zero),
    .less_than         (exp_lt),
    .less_than_unsigned(exp_ltu),
    .reserved          (exp_reserved)
  );

  assign match_c = (s1_result == exp_result) && (s1_zero == exp_zero) &&
                   (s1_lt == exp_lt) && (s1_ltu == exp_ltu);

  // Tally outcomes and latch the first mismatch of the run
  always_ff @(posedge clk) begin
    if (!rst_n || start_c) begin
      err            <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      skip_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_op  <= '0;
      first_fail_exp <= '0;
    end else if (s1_valid) begin
      if (exp_reserved) begin
        skip_cnt <= sat_inc(skip_cnt);
      end else if (match_c) begin
        pass_cnt <= sat_inc(pass_cnt);
      end else begin
        fail_cnt <= sat_inc(fail_cnt);
        if (!err) begin
          err            <= 1'b1;
          first_fail_idx <= s1_idx;
          first_fail_op  <= s1_op;
          first_fail_exp <= exp_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: expected outcomes queued at issue, popped on tally change.
module tb_alu_result_checker;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [CNT_W-1:0]      num_txn = '0;
  logic                  smp_valid = 1'b0;
  logic [WIDTH-1:0]      a = '0;
  logic [WIDTH-1:0]      b = '0;
  logic [ALU_CTRL_W-1:0] alu_control = '0;
  logic [WIDTH-1:0]      alu_result = '0;
  logic                  zero = 1'b0;
  logic                  less_than = 1'b0;
  logic                  less_than_unsigned = 1'b0;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [CNT_W-1:0]      pass_cnt;
  logic [CNT_W-1:0]      fail_cnt;
  logic [CNT_W-1:0]      skip_cnt;
  logic [CNT_W-1:0]      first_fail_idx;
  logic [ALU_CTRL_W-1:0] first_fail_op;
  logic [WIDTH-1:0]      first_fail_exp;

  alu_result_checker #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .num_txn           (num_txn),
    .smp_valid         (smp_valid),
    .a                 (a),
    .b                 (b),
    .alu_control       (alu_control),
    .alu_result        (alu_result),
    .zero              (zero),
    .less_than         (less_than),
    .less_than_unsigned(less_than_unsigned),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .pass_cnt          (pass_cnt),
    .fail_cnt          (fail_cnt),
    .skip_cnt          (skip_cnt),
    .first_fail_idx    (first_fail_idx),
    .first_fail_op     (first_fail_op),
    .first_fail_exp    (first_fail_exp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int sb[$];  // expected outcome per issued sample: 0 pass, 1 fail, 2 skip

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] vr, input logic vz, input logic vlt, input logic vltu,
                      input int outcome);
    smp_valid          = 1'b1;
    alu_control        = op;
    a                  = va;
    b                  = vb;
    alu_result         = vr;
    zero               = vz;
    less_than          = vlt;
    less_than_unsigned = vltu;
    if (outcome >= 0) sb.push_back(outcome);
    step();
    smp_valid = 1'b0;
  endtask

  task automatic do_start(input int n);
    start   = 1'b1;
    num_txn = CNT_W'(n);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    check(name, 64'(done), 64'd1);
  endtask

  // Monitor: each single-step tally change retires one expectation
  logic [CNT_W-1:0] pp = '0, pf = '0, ps = '0;
  always @(negedge clk) begin
    if (pass_cnt < pp || fail_cnt < pf || skip_cnt < ps) begin
      pp <= pass_cnt; pf <= fail_cnt; ps <= skip_cnt;
    end else if ((pass_cnt != pp) || (fail_cnt != pf) || (skip_cnt != ps)) begin
      int got;
      got = (pass_cnt != pp) ? 0 : (fail_cnt != pf) ? 1 : 2;
      if (sb.size() == 0) begin
        check("unexpected_tally", 64'(got), 64'd99);
      end else begin
        check("outcome", 64'(got), 64'(sb.pop_front()));
      end
      pp <= pass_cnt; pf <= fail_cnt; ps <= skip_cnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_pass", 64'(pass_cnt), 64'd0);
    check("rst_fail", 64'(fail_cnt), 64'd0);
    check("rst_skip", 64'(skip_cnt), 64'd0);
    check("rst_ff_idx", 64'(first_fail_idx), 64'd0);
    check("rst_ff_op", 64'(first_fail_op), 64'd0);
    check("rst_ff_exp", 64'(first_fail_exp), 64'd0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of a run
    do_start(8);
    check("mid_busy_up", 64'(busy), 64'd1);
    send(ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1, 1'b1, 0);
    send(ALU_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0, 0);
    send(ALU_XOR, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb.delete();
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check("mid_pass", 64'(pass_cnt), 64'd0);
    check("mid_fail", 64'(fail_cnt), 64'd0);
    check("mid_skip", 64'(skip_cnt), 64'd0);

    // All-correct run of ten transactions
    do_start(10);
    send(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b1, 1'b0, 0);
    send(ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
    send(ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1, 1'b1, 0);
    send(ALU_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0, 0);
    send(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b1, 1'b1, 0);
    send(ALU_OR, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b1, 1'b1, 0);
    send(ALU_XOR, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    send(ALU_SLT, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 0);
    send(ALU_SLTU, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 0);
    send(ALU_SLL, 32'd1, 32'd4, 32'h10, 1'b0, 1'b1, 1'b1, 0);
    check("ok_done_n1", 64'(done), 64'd0);
    step();
    check("ok_done_n2", 64'(done), 64'd0);
    check("ok_pass_n2", 64'(pass_cnt), 64'd10);
    step();
    check("ok_done_at_2", 64'(done), 64'd1);
    check("ok_busy", 64'(busy), 64'd0);
    check("ok_fail", 64'(fail_cnt), 64'd0);
    check("ok_err", 64'(err), 64'd0);

    // Injected failures, start pulsed mid-run, extra samples past the window
    do_start(5);
    send(ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1, 1'b1, 0);
    send(ALU_AND, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0, 1'b0, 0);
    start   = 1'b1;
    num_txn = CNT_W'(9);
    step();
    start = 1'b0;
    check("run_start_ignored_busy", 64'(busy), 64'd1);
    send(ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b1, 1);
    send(ALU_OR, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0);
    send(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1);
    send(ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, -1);
    send(ALU_ADD, 32'd2, 32'd2, 32'd5, 1'b0, 1'b0, 1'b0, -1);
    wait_done(20, "inj_done");
    check("inj_pass", 64'(pass_cnt), 64'd3);
    check("inj_fail", 64'(fail_cnt), 64'd2);
    check("inj_err", 64'(err), 64'd1);
    check("inj_ff_idx", 64'(first_fail_idx), 64'd2);
    check("inj_ff_op", 64'(first_fail_op), 64'd1);
    check("inj_ff_exp", 64'(first_fail_exp), 64'hFFFF_FFFE);

    // Restart from DONE clears the failing run
    do_start(4);
    check("rs_err", 64'(err), 64'd0);
    check("rs_fail", 64'(fail_cnt), 64'd0);
    check("rs_pass", 64'(pass_cnt), 64'd0);
    check("rs_ff_idx", 64'(first_fail_idx), 64'd0);
    check("rs_ff_exp", 64'(first_fail_exp), 64'd0);
    check("rs_done", 64'(done), 64'd0);
    check("rs_busy", 64'(busy), 64'd1);

    // Reserved opcodes interleaved with idle cycles
    send(4'd12, 32'd1, 32'd2, 32'hDEAD, 1'b1, 1'b1, 1'b1, 2);
    step();
    step();
    send(ALU_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1'b1, 1'b0, 0);
    step();
    send(4'd15, 32'd0, 32'd0, 32'hBEEF, 1'b0, 1'b0, 1'b0, 2);
    step();
    send(ALU_XOR, 32'd5, 32'd3, 32'd6, 1'b0, 1'b0, 1'b0, 0);
    wait_done(20, "rsv_done");
    check("rsv_skip", 64'(skip_cnt), 64'd2);
    check("rsv_pass", 64'(pass_cnt), 64'd2);
    check("rsv_fail", 64'(fail_cnt), 64'd0);

    // Zero-length run with smp_valid held high throughout
    smp_valid = 1'b1;
    do_start(0);
    check("z_done_n0", 64'(done), 64'd0);
    step();
    check("z_done_n1", 64'(done), 64'd1);
    step();
    smp_valid = 1'b0;
    step();
    check("z_pass", 64'(pass_cnt), 64'd0);
    check("z_skip", 64'(skip_cnt), 64'd0);
    check("z_fail", 64'(fail_cnt), 64'd0);

    repeat (3) step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
